// File: rtl/mem_bist.sv
// March-style memory BIST: write seed^addr to every word, read back and compare.
// Optional inverted second write/read pass when MEM_BIST_INV_PASS_EN is defined.
module mem_bist #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = '1;

    state_e              r_state, w_state_d;
    logic [ADDR_W-1:0]   r_cnt, w_cnt_d;
    logic [DATA_W-1:0]   r_seed;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_rd_valid;
    logic [ADDR_W:0]     r_err;
    logic [ADDR_W-1:0]   r_fail;
    logic                r_pass;
    logic [DATA_W-1:0]   w_wr_pat;
    logic [DATA_W-1:0]   w_rd_exp;
    logic                w_mismatch;

`ifdef MEM_BIST_INV_PASS_EN
    logic r_inv, w_inv_d;
    logic r_rd_inv;

    assign w_wr_pat = r_inv ? ~(r_seed ^ DATA_W'(r_cnt)) : (r_seed ^ DATA_W'(r_cnt));
    assign w_rd_exp = r_rd_inv ? ~(r_seed ^ DATA_W'(r_rd_addr)) : (r_seed ^ DATA_W'(r_rd_addr));
`else
    assign w_wr_pat = r_seed ^ DATA_W'(r_cnt);
    assign w_rd_exp = r_seed ^ DATA_W'(r_rd_addr);
`endif

    assign w_mismatch = r_rd_valid && (mem_rdata != w_rd_exp);

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
`ifdef MEM_BIST_INV_PASS_EN
        w_inv_d   = r_inv;
`endif
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d = StWrite;
                    w_cnt_d   = '0;
`ifdef MEM_BIST_INV_PASS_EN
                    w_inv_d   = 1'b0;
`endif
                end
            end
            StWrite: begin
                mem_write = 1'b1;
                mem_addr  = r_cnt;
                mem_wdata = w_wr_pat;
                w_cnt_d   = r_cnt + 1'b1;
                if (r_cnt == LastAddr) w_state_d = StRead;
            end
            StRead: begin
                mem_read = 1'b1;
                mem_addr = r_cnt;
                w_cnt_d  = r_cnt + 1'b1;
                if (r_cnt == LastAddr) begin
`ifdef MEM_BIST_INV_PASS_EN
                    if (!r_inv) begin
                        w_state_d = StWrite;
                        w_inv_d   = 1'b1;
                    end else begin
                        w_state_d = StDrain;
                    end
`else
                    w_state_d = StDrain;
`endif
                end
            end
            StDrain: w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_seed     <= '0;
            r_rd_addr  <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= '0;
            r_fail     <= '0;
            r_pass     <= 1'b0;
`ifdef MEM_BIST_INV_PASS_EN
            r_inv      <= 1'b0;
            r_rd_inv   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            // Read data returns one cycle later, so the compare uses the registered address.
            r_rd_valid <= (r_state == StRead);
            r_rd_addr  <= r_cnt;
`ifdef MEM_BIST_INV_PASS_EN
            r_inv      <= w_inv_d;
            r_rd_inv   <= r_inv;
`endif
            if (r_state == StIdle && start) begin
                r_seed <= seed;
                r_err  <= '0;
                r_fail <= '0;
                r_pass <= 1'b0;
            end else begin
                if (w_mismatch) begin
                    if (r_err != '1) r_err <= r_err + 1'b1;
                    if (r_err == '0) r_fail <= r_rd_addr;
                end
                if (r_state == StDrain) r_pass <= (r_err == '0) && !w_mismatch;
            end
        end
    end

    assign busy      = (r_state == StWrite) || (r_state == StRead) || (r_state == StDrain);
    assign done      = (r_state == StDone);
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_addr = r_fail;

endmodule

// File: tb/tb_mem_bist.sv
// Scoreboard bench for mem_bist: expected writes and results are queued by the stimulus,
// a monitor process pops and compares them as the DUT emits write strobes and done pulses.
module tb_mem_bist;
    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 32;
`ifdef MEM_BIST_INV_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int BUSY_CYC = 2 * PASSES * DEPTH + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] seed;
    logic          busy, done, pass;
    logic [AW:0]   err_count;
    logic [AW-1:0] fail_addr;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed      (seed),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory with per-address fault masks: stuck-at-1 (or), stuck-at-0 (clr), flip (xor).
    logic [DW-1:0] mem   [DEPTH];
    logic [DW-1:0] f_or  [DEPTH];
    logic [DW-1:0] f_clr [DEPTH];
    logic [DW-1:0] f_xor [DEPTH];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        if (mem_read)
            mem_rdata <= ((mem[mem_addr] | f_or[mem_addr]) & ~f_clr[mem_addr]) ^ f_xor[mem_addr];
    end

    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
    typedef struct packed {logic p; logic [AW:0] e; logic [AW-1:0] f;} res_t;
    wr_t  wq[$];
    res_t rq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin
            f_or[i]  = '0;
            f_clr[i] = '0;
            f_xor[i] = '0;
        end
    endtask

    task automatic monitor();
        int   busy_cnt = 0;
        logic prev_done = 1'b0;
        wr_t  w;
        res_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                if (busy) busy_cnt++;
                if (mem_read && mem_write) check("rw_excl", {31'd0, mem_write}, 32'd0);
                if (!busy && (mem_read || mem_write || mem_addr != '0 || mem_wdata != '0))
                    check("idle_quiet", {mem_read, mem_write, mem_addr, mem_wdata}, 32'd0);
                if (mem_write) begin
                    if (wq.size() == 0) begin
                        check("wr_unexp", {31'd0, mem_write}, 32'd0);
                    end else begin
                        w = wq.pop_front();
                        check("wr_addr", 32'(mem_addr), 32'(w.a));
                        check("wr_data", 32'(mem_wdata), 32'(w.d));
                    end
                end
                if (done) begin
                    if (prev_done) check("done_1cyc", {31'd0, prev_done}, 32'd0);
                    if (rq.size() == 0) begin
                        check("done_unexp", {31'd0, done}, 32'd0);
                    end else begin
                        r = rq.pop_front();
                        check("busy_len", busy_cnt, BUSY_CYC);
                        check("pass", {31'd0, pass}, {31'd0, r.p});
                        check("err_count", 32'(err_count), 32'(r.e));
                        check("fail_addr", 32'(fail_addr), 32'(r.f));
                    end
                    busy_cnt = 0;
                end
                prev_done = done;
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input logic [DW-1:0] s, input logic p, input logic [AW:0] e,
                               input logic [AW-1:0] f);
        logic [DW-1:0] d;
        for (int ps = 0; ps < PASSES; ps++) begin
            for (int k = 0; k < DEPTH; k++) begin
                d = s ^ DW'(k);
                if (ps == 1) d = ~d;
                wq.push_back({AW'(k), d});
            end
        end
        rq.push_back({p, e, f});
    endtask

    task automatic run_test(input string tag, input logic [DW-1:0] s, input logic p,
                            input logic [AW:0] e, input logic [AW-1:0] f, input bit repulse);
        push_expect(s, p, e, f);
        cyc(1);
        start = 1'b1;
        seed  = s;
        cyc(1);
        start = 1'b0;
        seed  = 8'h5C;
        check({tag, "_clr_err"}, 32'(err_count), 32'd0);
        check({tag, "_clr_pass"}, {31'd0, pass}, 32'd0);
        if (repulse) begin
            cyc(9);
            start = 1'b1;
            seed  = 8'hFF;
            cyc(1);
            start = 1'b0;
        end
        for (int i = 0; i < 400 && rq.size() != 0; i++) cyc(1);
        check({tag, "_done_seen"}, rq.size(), 32'd0);
        check({tag, "_writes"}, wq.size(), 32'd0);
        rq.delete();
        wq.delete();
        cyc(3);
        check({tag, "_pass_hold"}, {31'd0, pass}, {31'd0, p});
    endtask

    task automatic main();
        int dn;
        // Reset dominates start; outputs stay zero while held.
        rst   = 1'b1;
        start = 1'b1;
        seed  = 8'hA5;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("rst_outs", {busy, done, pass, err_count, fail_addr, mem_read, mem_write,
                               mem_addr, mem_wdata}, 32'd0);
            cyc(1);
        end
        start = 1'b0;
        rst   = 1'b0;
        cyc(2);

        run_test("clean", 8'hA5, 1'b1, '0, '0, 1'b0);

        // Stuck-at-1 on bit0 of addr 5 is masked by pattern 8'h05; only the inverted pass sees it.
        clear_faults();
        f_or[5] = 8'h01;
`ifdef MEM_BIST_INV_PASS_EN
        run_test("sa1", 8'h00, 1'b0, 6'd1, 5'd5, 1'b0);
`else
        run_test("sa1", 8'h00, 1'b1, 6'd0, 5'd0, 1'b0);
`endif

        clear_faults();
        f_clr[5] = 8'h01;
        run_test("sa0", 8'h00, 1'b0, 6'd1, 5'd5, 1'b0);

        clear_faults();
        f_xor[3]  = 8'h10;
        f_xor[20] = 8'h81;
`ifdef MEM_BIST_INV_PASS_EN
        run_test("two", 8'h3C, 1'b0, 6'd4, 5'd3, 1'b0);
`else
        run_test("two", 8'h3C, 1'b0, 6'd2, 5'd3, 1'b0);
`endif

        clear_faults();
        for (int i = 0; i < DEPTH; i++) f_xor[i] = 8'h01;
`ifdef MEM_BIST_INV_PASS_EN
        run_test("all", 8'h5A, 1'b0, 6'd63, 5'd0, 1'b0);
`else
        run_test("all", 8'h5A, 1'b0, 6'd32, 5'd0, 1'b0);
`endif

        clear_faults();
        run_test("repulse", 8'hA5, 1'b1, '0, '0, 1'b1);

        // Abort mid-READ: strobe must fall asynchronously and no done may follow.
        push_expect(8'hA5, 1'b1, '0, '0);
        cyc(1);
        start = 1'b1;
        seed  = 8'hA5;
        cyc(1);
        start = 1'b0;
        cyc(39);
        check("mid_read", {31'd0, mem_read}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_read", {31'd0, mem_read}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        wq.delete();
        rq.delete();
        cyc(2);
        rst = 1'b0;
        dn  = 0;
        for (int i = 0; i < 150; i++) begin
            cyc(1);
            if (done) dn++;
        end
        check("no_done_abort", dn, 32'd0);

        run_test("after_rst", 8'hA5, 1'b1, '0, '0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        seed      = '0;
        mem_rdata = '0;
        clear_faults();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        fork
            monitor();
            main();
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
